// File: rtl/id_pkg.sv
// Shared encodings for the decode stage: opcode classes, extender selects,
// sequencer states and instruction field positions.
package id_pkg;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_JMP = 2'b10,
    OP_SYS = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    EXT_DP   = 2'b00,
    EXT_MEM  = 2'b01,
    EXT_JMP  = 2'b10,
    EXT_ZERO = 2'b11
  } ext_t;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_STALL   = 2'b01,
    ST_FLUSH   = 2'b10,
    ST_WAIT_EX = 2'b11
  } state_t;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 30;
  localparam int IL_BIT = 29;
  localparam int RD_HI  = 28;
  localparam int RD_LO  = 25;
  localparam int RS1_HI = 24;
  localparam int RS1_LO = 21;
  localparam int RS2_HI = 20;
  localparam int RS2_LO = 17;

  typedef struct packed {
    op_t        op;
    ext_t       ext_sel;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src_imm;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
  } dec_t;

  function automatic ext_t ext_of(input op_t op);
    case (op)
      OP_DP:   return EXT_DP;
      OP_MEM:  return EXT_MEM;
      OP_JMP:  return EXT_JMP;
      default: return EXT_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/id_decoder.sv
// Purely combinational field extraction and control decode of one instruction.
module id_decoder
  import id_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] instr,
  output dec_t         dec
);

  op_t  op;
  logic il;
  logic unused_bits;

  // Immediate and upper bits belong to later stages; fold them so they count as read.
  assign unused_bits = ^instr;

  always_comb begin
    op              = op_t'(instr[OP_HI:OP_LO]);
    il              = instr[IL_BIT];
    dec             = '0;
    dec.op          = op;
    dec.ext_sel     = ext_of(op);
    dec.rd          = instr[RD_HI:RD_LO];
    dec.rs1         = instr[RS1_HI:RS1_LO];
    dec.rs2         = instr[RS2_HI:RS2_LO];
    case (op)
      OP_DP: begin
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = il;
      end
      OP_MEM: begin
        dec.alu_src_imm = 1'b1;
        if (il) begin
          dec.mem_read  = 1'b1;
          dec.reg_write = 1'b1;
        end else begin
          dec.mem_write = 1'b1;
        end
      end
      OP_JMP:  dec.branch    = 1'b1;
      default: dec.reg_write = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_sequencer.sv
// Decode stage: instruction register toward EX plus the RUN/STALL/FLUSH/WAIT_EX
// sequencer handling load-use bubbles, jump flushes and multi-cycle SYS ops.
module id_sequencer
  import id_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         if_valid,
  input  logic [N-1:0] if_instr,
  output logic         id_ready,
  input  logic         ex_ready,
  input  logic         ex_done,
  output logic         ex_valid,
  output logic [1:0]   ext_selector,
  output logic         reg_write,
  output logic         mem_read,
  output logic         mem_write,
  output logic         branch,
  output logic         alu_src_imm,
  output logic [3:0]   rd,
  output logic         flush,
  output logic         busy,
  output state_t       state
);

  // Handshakes: an instruction moves IF->ID on a cycle where if_valid && id_ready,
  // and ID->EX on a cycle where ex_valid && ex_ready; a held ex_valid keeps all
  // decode outputs frozen until EX takes them.

  dec_t   dec;
  state_t state_nxt;
  logic   accept;
  logic   run_accept;
  logic   hazard;
  logic   stall_req;

  id_decoder #(.N(N)) u_decoder (
    .instr (if_instr),
    .dec   (dec)
  );

  always_comb begin
    case (state)
      ST_RUN:   id_ready = !ex_valid || ex_ready;
      ST_FLUSH: id_ready = 1'b1;
      default:  id_ready = 1'b0;
    endcase
  end

  assign accept     = if_valid && id_ready;
  assign run_accept = accept && (state == ST_RUN);
  assign hazard     = ex_valid && mem_read && ((dec.rs1 == rd) || (dec.rs2 == rd));
  // A jump wins over load-use: it issues at once and its follower is flushed anyway.
  assign stall_req  = hazard && (dec.op != OP_JMP);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (run_accept) begin
          if (dec.op == OP_JMP)      state_nxt = ST_FLUSH;
          else if (stall_req)        state_nxt = ST_STALL;
          else if (dec.op == OP_SYS) state_nxt = ST_WAIT_EX;
        end
      end
      // A SYS held back by the bubble still needs its completion wait once issued.
      ST_STALL:   state_nxt = (ext_selector == EXT_ZERO) ? ST_WAIT_EX : ST_RUN;
      ST_FLUSH:   state_nxt = ST_RUN;
      ST_WAIT_EX: if (ex_done) state_nxt = ST_RUN;
      default:    state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
      busy  <= 1'b0;
      flush <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_RUN);
      flush <= (state_nxt == ST_FLUSH);
    end
  end

  // During a bubble the register already holds the stalled instruction with ex_valid low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid     <= 1'b0;
      ext_selector <= EXT_DP;
      reg_write    <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      branch       <= 1'b0;
      alu_src_imm  <= 1'b0;
      rd           <= '0;
    end else if (run_accept) begin
      ex_valid     <= !stall_req;
      ext_selector <= dec.ext_sel;
      reg_write    <= dec.reg_write;
      mem_read     <= dec.mem_read;
      mem_write    <= dec.mem_write;
      branch       <= dec.branch;
      alu_src_imm  <= dec.alu_src_imm;
      rd           <= dec.rd;
    end else if (state == ST_STALL) begin
      ex_valid <= 1'b1;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_sequencer.sv
// Self-checking bench for id_sequencer: vector table, directed corner sequences
// and random traffic against a cycle-level reference model.
module tb_id_sequencer;
  import id_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        id_ready;
  logic        ex_ready;
  logic        ex_done;
  logic        ex_valid;
  logic [1:0]  ext_selector;
  logic        reg_write, mem_read, mem_write, branch, alu_src_imm;
  logic [3:0]  rd;
  logic        flush;
  logic        busy;
  state_t      state;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  id_sequencer #(.N(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .id_ready     (id_ready),
    .ex_ready     (ex_ready),
    .ex_done      (ex_done),
    .ex_valid     (ex_valid),
    .ext_selector (ext_selector),
    .reg_write    (reg_write),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .branch       (branch),
    .alu_src_imm  (alu_src_imm),
    .rd           (rd),
    .flush        (flush),
    .busy         (busy),
    .state        (state)
  );

  // ---------------- reference model + scoreboard ----------------
  logic [10:0] exp_q[$];
  bit          m_valid, m_last_load, stall_pending, flush_window, sys_wait;
  int          m_last_rd;
  logic [31:0] held;
  bit          e_ready;

  // {ext_selector, reg_write, mem_read, mem_write, branch, alu_src_imm, rd}
  function automatic logic [10:0] model_decode(input logic [31:0] i);
    int op, il, rdv;
    bit rw, mr, mw, br, imm;
    op = int'((i >> 30) & 32'd3);
    il = int'((i >> 29) & 32'd1);
    rdv = int'((i >> 25) & 32'd15);
    rw = 0; mr = 0; mw = 0; br = 0; imm = 0;
    if (op == 0) begin rw = 1; imm = (il == 1); end
    else if (op == 1) begin imm = 1; if (il == 1) begin mr = 1; rw = 1; end else mw = 1; end
    else if (op == 2) br = 1;
    else rw = 1;
    return {2'(op), rw, mr, mw, br, imm, 4'(rdv)};
  endfunction

  function automatic logic [10:0] dut_decode();
    return {ext_selector, reg_write, mem_read, mem_write, branch, alu_src_imm, rd};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_last_load = 0; m_last_rd = 0;
    stall_pending = 0; flush_window = 0; sys_wait = 0;
    held = '0;
    exp_q.delete();
  endtask

  task automatic model_issue(input logic [31:0] i);
    int op;
    op = int'((i >> 30) & 32'd3);
    exp_q.push_back(model_decode(i));
    m_valid     = 1;
    m_last_load = (op == 1) && (((i >> 29) & 32'd1) == 32'd1);
    m_last_rd   = int'((i >> 25) & 32'd15);
    if (op == 3) sys_wait = 1;
  endtask

  task automatic model_check();
    e_ready = flush_window ? 1'b1 : (stall_pending || sys_wait) ? 1'b0 : (!m_valid || ex_ready);
    chk("id_ready", id_ready, e_ready);
    chk("ex_valid", ex_valid, m_valid);
    chk("busy", busy, stall_pending || flush_window || sys_wait);
    chk("flush", flush, flush_window);
    if (m_valid) begin
      if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
      else chk("decode", dut_decode(), exp_q[0]);
    end
  endtask

  task automatic model_update();
    bit acc, hz_base, lu;
    int op, rs1, rs2;
    acc     = if_valid && e_ready;
    hz_base = m_valid && m_last_load;
    if (m_valid && ex_ready) begin
      m_valid = 0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (flush_window) flush_window = 0;
    else if (stall_pending) begin stall_pending = 0; model_issue(held); end
    else if (sys_wait) begin if (ex_done) sys_wait = 0; end
    else if (acc) begin
      op  = int'((if_instr >> 30) & 32'd3);
      rs1 = int'((if_instr >> 21) & 32'd15);
      rs2 = int'((if_instr >> 17) & 32'd15);
      lu  = hz_base && ((rs1 == m_last_rd) || (rs2 == m_last_rd));
      if (op == 2) begin model_issue(if_instr); flush_window = 1; end
      else if (lu) begin stall_pending = 1; held = if_instr; end
      else model_issue(if_instr);
    end
  endtask

  // ---------------- driver ----------------
  // Drives one cycle at the falling edge, checks against the model, then
  // advances the model to the post-edge state. Returns before the rising edge.
  task automatic cycle(input logic v, input logic [31:0] i, input logic r, input logic d);
    @(negedge clk);
    if_valid = v; if_instr = i; ex_ready = r; ex_done = d;
    #1;
    model_check();
    model_update();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ex_valid"}, ex_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_flush"}, flush, 0);
    chk({tag, "_decode"}, dut_decode(), 0);
    chk({tag, "_state"}, state, ST_RUN);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [10:0] exp;
  } vec_t;
  vec_t vecs[8];

  initial begin
    rst = 1'b0; if_valid = 0; if_instr = '0; ex_ready = 0; ex_done = 0;
    model_reset();
    #1;
    check_reset_values("reset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // ---- vector table: {instr, {ext, rw, mr, mw, br, imm, rd}} ----
    vecs[0] = '{32'h2000_0004, {2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0}};
    vecs[1] = '{32'h0220_0000, {2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1}};
    vecs[2] = '{32'h6200_0000, {2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1}};
    vecs[3] = '{32'h4A00_0000, {2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5}};
    vecs[4] = '{32'h8000_0010, {2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0}};
    vecs[5] = '{32'hDE00_0000, {2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15}};
    vecs[6] = '{32'hF000_0000, {2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8}};
    vecs[7] = '{32'h3E00_0000, {2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd15}};
    for (int k = 0; k < 8; k++) begin
      cycle(1, vecs[k].instr, 1, 0);
      cycle(0, 32'h0, 1, 1);
      chk($sformatf("vec%0d_valid", k), ex_valid, 1);
      chk($sformatf("vec%0d_decode", k), dut_decode(), vecs[k].exp);
    end
    cycle(0, 32'h0, 1, 0);

    // ---- load-use: one bubble, then the dependent DP issues ----
    cycle(1, 32'h6200_0000, 1, 0);
    cycle(1, 32'h0020_0000, 1, 0);
    chk("lu_load_issued", mem_read, 1);
    cycle(0, 32'h0, 1, 0);
    chk("lu_bubble_ready", id_ready, 0);
    chk("lu_bubble_busy", busy, 1);
    chk("lu_bubble_valid", ex_valid, 0);
    cycle(0, 32'h0, 1, 0);
    chk("lu_dp_valid", ex_valid, 1);
    chk("lu_dp_rw", reg_write, 1);
    chk("lu_dp_busy", busy, 0);

    // ---- jump: one flush cycle, follower discarded ----
    cycle(1, 32'h8000_0010, 1, 0);
    cycle(1, 32'h2000_0004, 1, 0);
    chk("jmp_flush", flush, 1);
    chk("jmp_ext", ext_selector, 2'b10);
    chk("jmp_ready", id_ready, 1);
    cycle(0, 32'h0, 1, 0);
    chk("jmp_flush_end", flush, 0);
    chk("jmp_discard", ex_valid, 0);

    // ---- SYS with ex_done five cycles late, then a stray ex_done ----
    cycle(1, 32'hC000_0000, 1, 0);
    for (int k = 0; k < 5; k++) begin
      cycle(1, 32'h2000_0004, 1, 0);
      chk("sys_wait_ready", id_ready, 0);
      chk("sys_wait_state", state, ST_WAIT_EX);
    end
    cycle(1, 32'h2000_0004, 1, 1);
    chk("sys_done_ready", id_ready, 0);
    cycle(1, 32'h2000_0004, 1, 0);
    chk("sys_back_run", state, ST_RUN);
    cycle(0, 32'h0, 1, 1);
    chk("stray_done_busy", busy, 0);
    cycle(0, 32'h0, 1, 0);
    chk("stray_done_state", state, ST_RUN);

    // ---- EX back-pressure for three cycles ----
    cycle(1, 32'h3E00_0000, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 32'h8000_0010, 0, 0);
      chk("hold_rd", rd, 4'd15);
      chk("hold_imm", alu_src_imm, 1);
      chk("hold_ready", id_ready, 0);
    end
    cycle(0, 32'h0, 1, 0);

    // ---- asynchronous reset in the middle of WAIT_EX ----
    cycle(1, 32'hC000_0000, 1, 0);
    cycle(0, 32'h0, 0, 0);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b0;
    if_valid = 0;
    #1;
    check_reset_values("rst_wait_ex");
    model_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    cycle(1, 32'h2000_0004, 1, 0);
    chk("post_rst_accept", id_ready, 1);
    cycle(0, 32'h0, 1, 0);
    chk("post_rst_issue", ex_valid, 1);

    // ---- random traffic against the model ----
    for (int c = 0; c < 800; c++) begin
      logic [31:0] ri;
      ri = {2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 17'($urandom)};
      cycle(1'($urandom_range(0, 9) < 7), ri, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 4) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_sequencer.md
ID_SEQUENCER -- requirements
Module: id_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning the instruction and datapath width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port if_valid, input, 1 bit: if_instr is valid.
REQ-005 The block SHALL have port if_instr, input, N bits: the fetched instruction.
REQ-006 The block SHALL have port id_ready, output, 1 bit: the block accepts if_instr this cycle.
REQ-007 The block SHALL have port ex_ready, input, 1 bit: EX accepts the registered decode.
REQ-008 The block SHALL have port ex_done, input, 1 bit: single-cycle pulse when a multi-cycle SYS operation completes.
REQ-009 The block SHALL have port ex_valid, output, 1 bit: the registered decode is valid.
REQ-010 The block SHALL have port ext_selector, output, 2 bits: the zero-extension type for the issued instruction.
REQ-011 The block SHALL have the following control ports, output, 1 bit each: reg_write, mem_read, mem_write, branch, alu_src_imm.
REQ-012 The block SHALL have port rd, output, 4 bits: the destination register of the issued instruction.
REQ-013 The block SHALL have port flush, output, 1 bit: discard the wrong-path fetch.
REQ-014 The block SHALL have port busy, output, 1 bit: the FSM is not in RUN.

Function
REQ-015 The instruction SHALL be decoded from these fields: [31:30] op_type (00 DP, 01 MEM, 10 JMP, 11 SYS); [29] I/L bit; [28:25] rd; [24:21] rs1; [20:17] rs2.
REQ-016 ext_selector SHALL be DP=00, MEM=01, JMP=10, SYS=11 (the extender outputs zero for 11).
REQ-017 Control decode SHALL be as follows: DP gives reg_write=1 and alu_src_imm=[29]; MEM with L=1 gives mem_read=1, reg_write=1, alu_src_imm=1; MEM with L=0 gives mem_write=1, alu_src_imm=1; JMP gives branch=1; SYS gives reg_write=1.
REQ-018 An instruction SHALL be accepted when if_valid && id_ready; its decode SHALL be registered and ex_valid SHALL assert on the next cycle (latency 1).
REQ-019 While ex_valid=1 and ex_ready=0, all decode outputs SHALL hold stable and id_ready SHALL be 0.
REQ-020 The FSM SHALL have exactly four states: RUN, STALL, FLUSH, WAIT_EX.
REQ-021 In RUN, id_ready SHALL equal (!ex_valid || ex_ready).
REQ-022 Load-use: if the issued instruction is a load and the incoming valid instruction reads rs1 or rs2 equal to its rd, the FSM SHALL go RUN to STALL. In STALL, id_ready=0 and a one-cycle bubble (ex_valid=0) SHALL be inserted, then the FSM SHALL return to RUN.
REQ-023 JMP accepted: the FSM SHALL go RUN to FLUSH. In FLUSH, flush=1 and id_ready=1 for one cycle, any accepted instruction SHALL be discarded (ex_valid=0 next cycle), then the FSM SHALL return to RUN.
REQ-024 SYS accepted: the FSM SHALL go RUN to WAIT_EX. In WAIT_EX, id_ready=0 until ex_done=1; the FSM SHALL return to RUN on the cycle after ex_done.
REQ-025 ex_done received outside WAIT_EX SHALL be ignored.
REQ-026 If the load-use check and a JMP issue coincide, FLUSH SHALL take priority; hazard detection SHALL be suppressed on flushed instructions.
REQ-027 ex_valid SHALL drop once EX accepts an instruction and no new instruction was accepted.

Reset
REQ-028 On rst=0, asynchronously: FSM=RUN; ex_valid, flush, busy, and all control outputs = 0; ext_selector=00; rd=0.
REQ-029 A reset asserted mid-STALL, mid-FLUSH, or mid-WAIT_EX SHALL abandon the operation; no pending instruction SHALL survive reset.
REQ-030 The first instruction SHALL be accepted on the first clock edge after rst deasserts.

Structure
REQ-031 op_type encodings, ext_selector encodings, the FSM state enum, and instruction field bit positions SHALL reside in shared package id_pkg.
REQ-032 Combinational decode SHALL be the sub-module id_decoder; the FSM, pipeline register, and hazard logic SHALL reside in id_sequencer.

Verification
REQ-033 DP immediate 0x20000004 with ex_ready=1 SHALL yield, next cycle: ex_valid=1, ext_selector=00, reg_write=1, alu_src_imm=1.
REQ-034 Load 0x62000000 (rd=1) followed by DP with rs1=1 SHALL yield exactly one bubble cycle with id_ready=0 and busy=1, after which the DP issues.
REQ-035 JMP 0x80000010 followed by any instruction SHALL yield flush=1 for one cycle, the follower discarded, and ext_selector=10.
REQ-036 SYS 0xC0000000 with ex_done delayed 5 cycles SHALL keep id_ready=0 for those cycles and return to RUN after ex_done; a stray ex_done pulse in RUN SHALL cause no effect.
REQ-037 ex_ready held 0 for 3 cycles SHALL leave the outputs stable; rst pulsed during WAIT_EX SHALL restore all outputs to their reset values immediately.
